adc_pair_read_scheduler: RTL and testbench

- Read-side controller for the two ADC clock-crossing FIFOs (channel A, channel B), in the alg_clk domain.
- Pops both FIFOs in lockstep so every output word is a time-aligned A/B sample pair, presented on a valid/ready interface to the algorithm datapath.
- Detects overflow (full) and inter-channel skew, and resynchronises the channels by pulsing a shared FIFO reset followed by a settle window.

---
 rtl/adc_pair_read_scheduler_if.sv | 13 +
 rtl/adc_pair_read_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_adc_pair_read_scheduler.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pair_read_scheduler_if.sv
// Aligned A/B sample-pair bus from the read scheduler to the algorithm datapath.
// The master drives the pair and valid; the slave returns ready.
interface adc_pair_read_scheduler_if #(
    parameter int DW = 16
);
    logic [DW-1:0] pair_a;
    logic [DW-1:0] pair_b;
    logic          pair_valid;
    logic          pair_ready;

    modport master (output pair_a, output pair_b, output pair_valid, input pair_ready);
    modport slave  (input pair_a, input pair_b, input pair_valid, output pair_ready);
endinterface

// File: rtl/adc_pair_read_scheduler.sv
// Lockstep reader for the channel A/B ADC FIFOs with overflow/skew resync flushes.
// Optional statistics outputs (pair_cnt, max_skew) are enabled by ADC_PAIR_SCHED_STATS_EN.
module adc_pair_read_scheduler #(
    parameter int DW            = 16,
    parameter int SKEW_TIMEOUT  = 64,
    parameter int RST_CYCLES    = 8,
    parameter int SETTLE_CYCLES = 32,
    parameter int CNT_W         = 16
) (
    input  logic                       alg_clk,
    input  logic                       alg_rst_n,
    input  logic                       enable,
    input  logic                       empty_a,
    input  logic                       empty_b,
    input  logic                       full_a,
    input  logic                       full_b,
    input  logic [DW-1:0]              dout_a,
    input  logic [DW-1:0]              dout_b,
    output logic                       rd_en_a,
    output logic                       rd_en_b,
    output logic                       fifo_rst,
    adc_pair_read_scheduler_if.master  pair_if,
    output logic [CNT_W-1:0]           overflow_cnt,
    output logic [CNT_W-1:0]           skew_cnt,
`ifdef ADC_PAIR_SCHED_STATS_EN
    output logic [31:0]                pair_cnt,
    output logic [CNT_W-1:0]           max_skew,
`endif
    output logic                       busy_flush
);
    localparam int TW    = $clog2(SKEW_TIMEOUT + 1);
    localparam int PMAX  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int PW    = $clog2(PMAX + 1);

    typedef enum logic [2:0] {WAIT, POP, CAP, HOLD, FLUSH, SETTLE} state_t;

    state_t            state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic              fifo_rst_q, fifo_rst_d;
    logic              busy_q, busy_d;
    logic              pair_valid_q, pair_valid_d;
    logic [DW-1:0]     pair_a_q, pair_a_d;
    logic [DW-1:0]     pair_b_q, pair_b_d;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]  skew_cnt_q, skew_cnt_d;
    logic [TW-1:0]     skew_tmr_q, skew_tmr_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic              one_side;
`ifdef ADC_PAIR_SCHED_STATS_EN
    logic [31:0]       pair_cnt_q, pair_cnt_d;
    logic [CNT_W-1:0]  max_skew_q, max_skew_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign one_side = empty_a ^ empty_b;

    always_comb begin
        state_d      = state_q;
        rd_en_d      = 1'b0;
        fifo_rst_d   = 1'b0;
        busy_d       = 1'b0;
        pair_valid_d = pair_valid_q;
        pair_a_d     = pair_a_q;
        pair_b_d     = pair_b_q;
        ovf_cnt_d    = ovf_cnt_q;
        skew_cnt_d   = skew_cnt_q;
        skew_tmr_d   = '0;
        phase_d      = '0;
        case (state_q)
            WAIT: begin
                // Overflow beats skew beats a normal pop; flush checks ignore enable.
                if (full_a || full_b) begin
                    state_d    = FLUSH;
                    fifo_rst_d = 1'b1;
                    busy_d     = 1'b1;
                    ovf_cnt_d  = sat_inc(ovf_cnt_q);
                end else if (skew_tmr_q == TW'(SKEW_TIMEOUT - 1)) begin
                    state_d    = FLUSH;
                    fifo_rst_d = 1'b1;
                    busy_d     = 1'b1;
                    skew_cnt_d = sat_inc(skew_cnt_q);
                end else if (enable && !empty_a && !empty_b) begin
                    state_d = POP;
                    rd_en_d = 1'b1;
                end else if (one_side) begin
                    skew_tmr_d = skew_tmr_q + 1'b1;
                end
            end
            POP:  state_d = CAP;
            CAP: begin
                // Non-FWFT FIFOs: dout is valid the cycle after the rd_en pulse.
                pair_a_d     = dout_a;
                pair_b_d     = dout_b;
                pair_valid_d = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (pair_if.pair_ready) begin
                    pair_valid_d = 1'b0;
                    state_d      = WAIT;
                end
            end
            FLUSH: begin
                busy_d     = 1'b1;
                fifo_rst_d = 1'b1;
                phase_d    = phase_q + 1'b1;
                if (phase_q == PW'(RST_CYCLES - 1)) begin
                    state_d    = SETTLE;
                    fifo_rst_d = 1'b0;
                    phase_d    = '0;
                end
            end
            SETTLE: begin
                busy_d  = 1'b1;
                phase_d = phase_q + 1'b1;
                if (phase_q == PW'(SETTLE_CYCLES - 1)) begin
                    state_d = WAIT;
                    busy_d  = 1'b0;
                    phase_d = '0;
                end
            end
            default: state_d = WAIT;
        endcase
    end

`ifdef ADC_PAIR_SCHED_STATS_EN
    always_comb begin
        pair_cnt_d = pair_cnt_q + 32'(pair_valid_q & pair_if.pair_ready);
        max_skew_d = (CNT_W'(skew_tmr_q) > max_skew_q) ? CNT_W'(skew_tmr_q) : max_skew_q;
    end
`endif

    always_ff @(posedge alg_clk or negedge alg_rst_n) begin
        if (!alg_rst_n) begin
            state_q      <= WAIT;
            rd_en_q      <= 1'b0;
            fifo_rst_q   <= 1'b0;
            busy_q       <= 1'b0;
            pair_valid_q <= 1'b0;
            pair_a_q     <= '0;
            pair_b_q     <= '0;
            ovf_cnt_q    <= '0;
            skew_cnt_q   <= '0;
            skew_tmr_q   <= '0;
            phase_q      <= '0;
`ifdef ADC_PAIR_SCHED_STATS_EN
            pair_cnt_q   <= '0;
            max_skew_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rd_en_q      <= rd_en_d;
            fifo_rst_q   <= fifo_rst_d;
            busy_q       <= busy_d;
            pair_valid_q <= pair_valid_d;
            pair_a_q     <= pair_a_d;
            pair_b_q     <= pair_b_d;
            ovf_cnt_q    <= ovf_cnt_d;
            skew_cnt_q   <= skew_cnt_d;
            skew_tmr_q   <= skew_tmr_d;
            phase_q      <= phase_d;
`ifdef ADC_PAIR_SCHED_STATS_EN
            pair_cnt_q   <= pair_cnt_d;
            max_skew_q   <= max_skew_d;
`endif
        end
    end

    assign rd_en_a            = rd_en_q;
    assign rd_en_b            = rd_en_q;
    assign fifo_rst           = fifo_rst_q;
    assign busy_flush         = busy_q;
    assign pair_if.pair_a     = pair_a_q;
    assign pair_if.pair_b     = pair_b_q;
    assign pair_if.pair_valid = pair_valid_q;
    assign overflow_cnt       = ovf_cnt_q;
    assign skew_cnt           = skew_cnt_q;
`ifdef ADC_PAIR_SCHED_STATS_EN
    assign pair_cnt           = pair_cnt_q;
    assign max_skew           = max_skew_q;
`endif
endmodule

// File: tb/tb_adc_pair_read_scheduler.sv
// Directed bench for adc_pair_read_scheduler with a small behavioural model of the two FIFOs.
module tb_adc_pair_read_scheduler;
    localparam int DW    = 16;
    localparam int CNT_W = 16;

    logic            alg_clk   = 1'b0;
    logic            alg_rst_n = 1'b1;
    logic            enable    = 1'b0;
    logic            full_a    = 1'b0;
    logic            full_b    = 1'b0;
    logic            empty_a, empty_b;
    logic [DW-1:0]   dout_a = '0, dout_b = '0;
    logic            rd_en_a, rd_en_b, fifo_rst, busy_flush;
    logic [CNT_W-1:0] overflow_cnt, skew_cnt;
`ifdef ADC_PAIR_SCHED_STATS_EN
    logic [31:0]     pair_cnt;
    logic [CNT_W-1:0] max_skew;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    adc_pair_read_scheduler_if #(.DW(DW)) bus ();

    adc_pair_read_scheduler #(.DW(DW), .CNT_W(CNT_W)) dut (
        .alg_clk      (alg_clk),
        .alg_rst_n    (alg_rst_n),
        .enable       (enable),
        .empty_a      (empty_a),
        .empty_b      (empty_b),
        .full_a       (full_a),
        .full_b       (full_b),
        .dout_a       (dout_a),
        .dout_b       (dout_b),
        .rd_en_a      (rd_en_a),
        .rd_en_b      (rd_en_b),
        .fifo_rst     (fifo_rst),
        .pair_if      (bus),
        .overflow_cnt (overflow_cnt),
        .skew_cnt     (skew_cnt),
`ifdef ADC_PAIR_SCHED_STATS_EN
        .pair_cnt     (pair_cnt),
        .max_skew     (max_skew),
`endif
        .busy_flush   (busy_flush)
    );

    always #5 alg_clk = ~alg_clk;

    // FIFO model: write pointers owned by the stimulus, read pointers by this process.
    logic [DW-1:0] mem_a [64];
    logic [DW-1:0] mem_b [64];
    int na = 0, nb = 0, ra = 0, rb = 0;
    assign empty_a = (ra >= na);
    assign empty_b = (rb >= nb);

    always @(posedge alg_clk) begin
        if (fifo_rst) begin
            ra <= na;
            rb <= nb;
        end else begin
            if (rd_en_a) begin dout_a <= mem_a[ra]; ra <= ra + 1; end
            if (rd_en_b) begin dout_b <= mem_b[rb]; rb <= rb + 1; end
        end
    end

    task automatic tick();
        @(posedge alg_clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] a, input logic [DW-1:0] b);
        mem_a[na] = a; na = na + 1;
        mem_b[nb] = b; nb = nb + 1;
    endtask

    task automatic do_reset();
        alg_rst_n = 1'b0;
        tick();
        tick();
        alg_rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string nm, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.pair_valid) seen = 1;
        end
        n_checks++;
        if (!seen || bus.pair_a !== ea || bus.pair_b !== eb) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b a=%h b=%h, expected valid=1 a=%h b=%h",
                     nm, seen, bus.pair_a, bus.pair_b, ea, eb);
        end
    endtask

    task automatic test_reset();
        #1 alg_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_en_a, rd_en_b, fifo_rst, bus.pair_valid, busy_flush} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {rd_en_a, rd_en_b, fifo_rst, bus.pair_valid, busy_flush});
        end
        n_checks++;
        if ({bus.pair_a, bus.pair_b, overflow_cnt, skew_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got a=%h b=%h ovf=%0d skew=%0d expected all 0",
                     bus.pair_a, bus.pair_b, overflow_cnt, skew_cnt);
        end
        tick();
        alg_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int rd_cyc[$];
        int vld_cyc[$];
        logic [DW-1:0] ga[$];
        logic [DW-1:0] gb[$];
        int mism = 0;
        int exp_rd[3]  = '{0, 4, 8};
        int exp_vld[3] = '{2, 6, 10};
        logic [DW-1:0] ea[3] = '{16'h1111, 16'h2222, 16'h3333};
        logic [DW-1:0] eb[3] = '{16'hA001, 16'hA002, 16'hA003};
        enable = 1'b1;
        bus.pair_ready = 1'b1;
        load(16'h1111, 16'hA001);
        load(16'h2222, 16'hA002);
        load(16'h3333, 16'hA003);
        for (int c = 0; c < 14; c++) begin
            tick();
            if (rd_en_a) rd_cyc.push_back(c);
            if (rd_en_a !== rd_en_b) mism++;
            if (bus.pair_valid) begin
                vld_cyc.push_back(c);
                ga.push_back(bus.pair_a);
                gb.push_back(bus.pair_b);
            end
        end
        n_checks++;
        if (rd_cyc.size() != 3 || vld_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL basic_counts: got rd=%0d valid=%0d expected 3 and 3",
                     rd_cyc.size(), vld_cyc.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= rd_cyc.size() || rd_cyc[i] != exp_rd[i]) begin
                n_fail++;
                $display("FAIL basic_rd_cycle[%0d]: got %0d expected %0d", i,
                         (i < rd_cyc.size()) ? rd_cyc[i] : -1, exp_rd[i]);
            end
            n_checks++;
            if (i >= vld_cyc.size() || vld_cyc[i] != exp_vld[i] || ga[i] !== ea[i] || gb[i] !== eb[i]) begin
                n_fail++;
                $display("FAIL basic_pair[%0d]: got cyc=%0d a=%h b=%h expected cyc=%0d a=%h b=%h", i,
                         (i < vld_cyc.size()) ? vld_cyc[i] : -1,
                         (i < ga.size()) ? ga[i] : 16'h0, (i < gb.size()) ? gb[i] : 16'h0,
                         exp_vld[i], ea[i], eb[i]);
            end
        end
        n_checks++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL basic_lockstep: got %0d rd_en_a/rd_en_b differences expected 0", mism);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0, rd = 0;
        bus.pair_ready = 1'b0;
        load(16'h1111, 16'hA001);
        load(16'h4444, 16'hA004);
        wait_valid("bp_first_pair", 16'h1111, 16'hA001);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.pair_valid || bus.pair_a !== 16'h1111 || bus.pair_b !== 16'hA001) bad++;
            if (rd_en_a) rd++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", bad);
        end
        n_checks++;
        if (rd != 0) begin
            n_fail++;
            $display("FAIL bp_no_read: got %0d rd_en cycles expected 0", rd);
        end
        bus.pair_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.pair_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_handshake_drop: got valid=%b expected 0", bus.pair_valid);
        end
        wait_valid("bp_second_pair", 16'h4444, 16'hA004);
        tick();
        tick();
    endtask

    task automatic test_skew();
        int entry = -1, fr = 0, bz = 0, rd = 0;
        enable = 1'b1;
        mem_a[na] = 16'h5555; na = na + 1;
        for (int i = 1; i <= 100 && entry < 0; i++) begin
            tick();
            if (rd_en_a) rd++;
            if (fifo_rst) entry = i;
        end
        n_checks++;
        if (entry != 64) begin
            n_fail++;
            $display("FAIL skew_entry_cycle: got %0d expected 64", entry);
        end
        n_checks++;
        if (skew_cnt !== 16'd1 || overflow_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL skew_counters: got skew=%0d ovf=%0d expected 1 and 0", skew_cnt, overflow_cnt);
        end
`ifdef ADC_PAIR_SCHED_STATS_EN
        n_checks++;
        if (max_skew !== 16'd63) begin
            n_fail++;
            $display("FAIL skew_max: got %0d expected 63", max_skew);
        end
`endif
        fr = fifo_rst ? 1 : 0;
        bz = busy_flush ? 1 : 0;
        for (int j = 1; j < 60; j++) begin
            tick();
            if (fifo_rst) fr++;
            if (busy_flush) bz++;
            if (rd_en_a || rd_en_b) rd++;
        end
        n_checks++;
        if (fr != 8) begin
            n_fail++;
            $display("FAIL skew_fifo_rst_len: got %0d expected 8", fr);
        end
        n_checks++;
        if (bz != 40) begin
            n_fail++;
            $display("FAIL skew_busy_len: got %0d expected 40", bz);
        end
        n_checks++;
        if (rd != 0) begin
            n_fail++;
            $display("FAIL skew_no_read: got %0d rd_en cycles expected 0", rd);
        end
    endtask

    task automatic test_full_hold();
        int held = 0, bad_rd = 0;
        bit got = 0;
        logic [DW-1:0] ga = '0, gb = '0;
        bus.pair_ready = 1'b0;
        load(16'h6666, 16'hA006);
        wait_valid("full_pair", 16'h6666, 16'hA006);
        full_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.pair_valid && !fifo_rst && bus.pair_a === 16'h6666) held++;
        end
        n_checks++;
        if (held != 3) begin
            n_fail++;
            $display("FAIL full_hold_kept: got %0d held cycles expected 3", held);
        end
        bus.pair_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.pair_valid !== 1'b0 || fifo_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL full_handshake: got valid=%b fifo_rst=%b expected 0 0", bus.pair_valid, fifo_rst);
        end
        tick();
        n_checks++;
        if (fifo_rst !== 1'b1 || overflow_cnt !== 16'd1 || skew_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL full_flush_entry: got fifo_rst=%b ovf=%0d skew=%0d expected 1 1 1",
                     fifo_rst, overflow_cnt, skew_cnt);
        end
        full_a = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i == 10) load(16'h7777, 16'hA007);
            if ((rd_en_a || rd_en_b) && (busy_flush || fifo_rst)) bad_rd++;
            if (bus.pair_valid && !got) begin got = 1; ga = bus.pair_a; gb = bus.pair_b; end
        end
        n_checks++;
        if (bad_rd != 0) begin
            n_fail++;
            $display("FAIL full_no_read_in_flush: got %0d expected 0", bad_rd);
        end
        n_checks++;
        if (!got || ga !== 16'h7777 || gb !== 16'hA007) begin
            n_fail++;
            $display("FAIL full_resume_pair: got seen=%0b a=%h b=%h expected 1 7777 a007", got, ga, gb);
        end
    endtask

    task automatic test_reset_in_cap();
        bus.pair_ready = 1'b1;
        enable = 1'b1;
        load(16'h8888, 16'hA008);
        tick();
        n_checks++;
        if (rd_en_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rcap_pop: got rd_en=%b expected 1", rd_en_a);
        end
        tick();
        #1 alg_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_en_a, rd_en_b, fifo_rst, bus.pair_valid, busy_flush} !== 5'b0 ||
            {bus.pair_a, bus.pair_b, overflow_cnt, skew_cnt} !== '0) begin
            n_fail++;
            $display("FAIL rcap_async_clear: got ctrl=%b a=%h b=%h ovf=%0d skew=%0d expected all 0",
                     {rd_en_a, rd_en_b, fifo_rst, bus.pair_valid, busy_flush},
                     bus.pair_a, bus.pair_b, overflow_cnt, skew_cnt);
        end
        tick();
        tick();
        alg_rst_n = 1'b1;
        load(16'h9999, 16'hA009);
        wait_valid("rcap_resume_pair", 16'h9999, 16'hA009);
        tick();
    endtask

    task automatic test_enable_gate();
        int rd = 0;
        enable = 1'b0;
        bus.pair_ready = 1'b1;
        load(16'hCCCC, 16'hACCC);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rd_en_a || rd_en_b) rd++;
        end
        n_checks++;
        if (rd != 0) begin
            n_fail++;
            $display("FAIL enable_gate_idle: got %0d rd_en cycles expected 0", rd);
        end
        enable = 1'b1;
        wait_valid("enable_gate_pair", 16'hCCCC, 16'hACCC);
        tick();
    endtask

    task automatic test_back_to_back();
        int hs = 0, bad = 0;
        do_reset();
        enable = 1'b1;
        bus.pair_ready = 1'b1;
        for (int i = 0; i < 5; i++) load(16'h1000 + 16'(i), 16'hB000 + 16'(i));
        for (int c = 0; c < 24; c++) begin
            tick();
            if (bus.pair_valid && bus.pair_ready) begin
                if (bus.pair_a !== 16'h1000 + 16'(hs) || bus.pair_b !== 16'hB000 + 16'(hs)) bad++;
                hs++;
            end
        end
        tick();
        n_checks++;
        if (hs != 5 || bad != 0) begin
            n_fail++;
            $display("FAIL b2b_pairs: got %0d handshakes with %0d bad expected 5 with 0", hs, bad);
        end
`ifdef ADC_PAIR_SCHED_STATS_EN
        n_checks++;
        if (pair_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL b2b_pair_cnt: got %0d expected 5", pair_cnt);
        end
`endif
    endtask

    initial begin
        bus.pair_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_skew();
        test_full_hold();
        test_reset_in_cap();
        test_enable_gate();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "timeout");
    end
endmodule
